// File: rtl/simo_fifo.sv
// rtl/simo_fifo.sv - single-input multi-output FIFO; define SIMO_FIFO_ERR_EN to add sticky o_err
module simo_fifo #(
   parameter int DEPTH       = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_LENGTH = 9,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int CNT_WIDTH   = $clog2(DEPTH + 1),
   parameter int PCNT_WIDTH  = $clog2(DATA_LENGTH + 1)
) (
   input  logic                                    i_clk,
   input  logic                                    i_nrst,
   input  logic                                    i_clear,
   input  logic                                    i_write_en,
   input  logic [DATA_WIDTH-1:0]                   i_data,
   input  logic                                    i_pop_en,
   input  logic [PCNT_WIDTH-1:0]                   i_pop_count,
   output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  o_data,
   output logic [DATA_LENGTH-1:0]                  o_valid,
   output logic [CNT_WIDTH-1:0]                    o_count,
`ifdef SIMO_FIFO_ERR_EN
   output logic                                    o_err,
`endif
   output logic                                    o_empty,
   output logic                                    o_full
);

   logic [DATA_WIDTH-1:0] fifo [DEPTH];
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [CNT_WIDTH-1:0]  count;
   logic [31:0]           cnt32;
   logic [31:0]           req32;
   logic [31:0]           grant32;
   logic                  wr_acc;

   assign o_count = count;
   assign o_full  = (count == CNT_WIDTH'(DEPTH));
   assign o_empty = (count == '0);

   // Grant uses the pre-edge count, so a same-cycle write is never poppable.
   always_comb begin
      cnt32   = 32'(count);
      req32   = 32'(i_pop_count);
      grant32 = '0;
      if (req32 > 32'(DATA_LENGTH))
         req32 = 32'(DATA_LENGTH);
      if (i_pop_en)
         grant32 = (req32 < cnt32) ? req32 : cnt32;
      wr_acc = i_write_en && !o_full;
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc && !i_clear)
         fifo[w_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         count   <= '0;
         o_data  <= '0;
         o_valid <= '0;
      end else if (i_clear) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         count   <= '0;
         o_data  <= '0;
         o_valid <= '0;
      end else begin
         w_ptr <= w_ptr + ADDR_WIDTH'(wr_acc);
         r_ptr <= r_ptr + ADDR_WIDTH'(grant32);
         count <= CNT_WIDTH'(cnt32 + 32'(wr_acc) - grant32);
         // Pointer arithmetic wraps naturally because DEPTH is a power of two.
         for (int k = 0; k < DATA_LENGTH; k++) begin
            if (32'(k) < grant32) begin
               o_data[k]  <= fifo[r_ptr + ADDR_WIDTH'(k)];
               o_valid[k] <= 1'b1;
            end else begin
               o_data[k]  <= '0;
               o_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef SIMO_FIFO_ERR_EN
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst)
         o_err <= 1'b0;
      else if (i_clear)
         o_err <= 1'b0;
      else if ((i_write_en && o_full) || (i_pop_en && (req32 > cnt32)))
         o_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_simo_fifo.sv
// tb/tb_simo_fifo.sv - queue-model bench for simo_fifo (SIMO_FIFO_ERR_EN optional)
module tb_simo_fifo;

   localparam int DEPTH = 32;
   localparam int LEN   = 9;

   logic                 i_clk;
   logic                 i_nrst;
   logic                 i_clear;
   logic                 i_write_en;
   logic [7:0]           i_data;
   logic                 i_pop_en;
   logic [3:0]           i_pop_count;
   logic [0:LEN-1][7:0]  o_data;
   logic [LEN-1:0]       o_valid;
   logic [5:0]           o_count;
   logic                 o_empty;
   logic                 o_full;
`ifdef SIMO_FIFO_ERR_EN
   logic                 o_err;
`endif

   simo_fifo dut (
      .i_clk       (i_clk),
      .i_nrst      (i_nrst),
      .i_clear     (i_clear),
      .i_write_en  (i_write_en),
      .i_data      (i_data),
      .i_pop_en    (i_pop_en),
      .i_pop_count (i_pop_count),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_count     (o_count),
`ifdef SIMO_FIFO_ERR_EN
      .o_err       (o_err),
`endif
      .o_empty     (o_empty),
      .o_full      (o_full)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int                  n_tests;
   int                  n_fail;
   logic [7:0]          q[$];
   logic [0:LEN-1][7:0] exp_data;
   logic [LEN-1:0]      exp_valid;
   logic                exp_err;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("valid", 72'(o_valid), 72'(exp_valid));
      check("data",  72'(o_data), 72'(exp_data));
      check("count", 72'(o_count), 72'(q.size()));
      check("empty", 72'(o_empty), 72'(q.size() == 0));
      check("full",  72'(o_full), 72'(q.size() == DEPTH));
`ifdef SIMO_FIFO_ERR_EN
      check("err",   72'(o_err), 72'(exp_err));
`endif
   endtask

   // Model: the FIFO is a plain queue; a pop takes the oldest min(req, size) items.
   task automatic step(input logic we, input logic [7:0] d, input logic pe, input int pc, input logic clr);
      int n;
      int req;
      int g;
      i_write_en  = we;
      i_data      = d;
      i_pop_en    = pe;
      i_pop_count = 4'(pc);
      i_clear     = clr;
      n   = q.size();
      req = (pc > LEN) ? LEN : pc;
      exp_data  = '0;
      exp_valid = '0;
      if (clr) begin
         q.delete();
         exp_err = 1'b0;
      end else begin
         if ((we && n == DEPTH) || (pe && req > n))
            exp_err = 1'b1;
         g = pe ? ((req < n) ? req : n) : 0;
         for (int k = 0; k < g; k++) begin
            exp_data[k]  = q.pop_front();
            exp_valid[k] = 1'b1;
         end
         if (we && n < DEPTH)
            q.push_back(d);
      end
      @(posedge i_clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 0, 1'b0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_err = 1'b0;
      exp_data  = '0;
      exp_valid = '0;
      i_nrst = 1'b0;
      i_clear = 1'b0;
      i_write_en = 1'b0;
      i_data = '0;
      i_pop_en = 1'b0;
      i_pop_count = '0;
      #22;
      check_all();
      i_nrst = 1'b1;
      #2;

      // Nine writes then a full-width pop
      for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, 0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 9, 1'b0);
      check("r040_valid", 72'(o_valid), 72'h1FF);
      check("r040_lane8", 72'(o_data[8]), 72'h09);
      check("r040_empty", 72'(o_empty), 72'h1);
      idle();

      // Over-request pop
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 5, 1'b0);
      check("r041_valid", 72'(o_valid), 72'h007);
      check("r041_lane2", 72'(o_data[2]), 72'hA2);

      // Fill, rejected write, write+pop on full
      step(1'b0, 8'h00, 1'b0, 0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
      check("r042_full", 72'(o_full), 72'h1);
      step(1'b1, 8'hFF, 1'b0, 0, 1'b0);
      check("r042_cnt32", 72'(o_count), 72'd32);
      step(1'b1, 8'hEE, 1'b1, 4, 1'b0);
      check("r042_cnt28", 72'(o_count), 72'd28);

      // Pop window wrapping DEPTH-1 -> 0
      step(1'b0, 8'h00, 1'b0, 0, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 9, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 6, 1'b0);
      check("r043_lane0", 72'(o_data[0]), 72'hC0);
      check("r043_lane5", 72'(o_data[5]), 72'hC5);

      // Simultaneous write and pop
      step(1'b0, 8'h00, 1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 2, 1'b0);
      check("r044_cnt4", 72'(o_count), 72'd4);
      step(1'b0, 8'h00, 1'b1, 9, 1'b0);
      check("r044_last", 72'(o_data[3]), 72'h55);

      // Clear beats write and pop
      for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 5, 1'b1);
      check("r045_cnt0", 72'(o_count), 72'd0);

      // Reset in the middle of a valid pulse
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 3, 1'b0);
      i_pop_en = 1'b0;
      i_nrst = 1'b0;
      #1;
      q.delete();
      exp_err = 1'b0;
      exp_data = '0;
      exp_valid = '0;
      check("r045_rst_valid", 72'(o_valid), 72'h0);
      check_all();
      #13;
      i_nrst = 1'b1;
      step(1'b1, 8'h3C, 1'b1, 2, 1'b0);
      idle();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 3),
              int'($urandom_range(0, 15)), ($urandom_range(0, 127) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/simo_fifo.md
SIMO_FIFO -- requirements
Module: simo_fifo

Interface
REQ-001 Parameter DEPTH, default 32: entry count; SHALL be a power of two, at least 2 and at least DATA_LENGTH.
REQ-002 Parameter DATA_WIDTH, default 8: bits per entry.
REQ-003 Parameter DATA_LENGTH, default 9: output lanes per pop.
REQ-004 Parameter ADDR_WIDTH, default $clog2(DEPTH): pointer width.
REQ-005 Parameter CNT_WIDTH, default $clog2(DEPTH+1): occupancy width.
REQ-006 Parameter PCNT_WIDTH, default $clog2(DATA_LENGTH+1): pop-request width.
REQ-007 i_clk  input  1  clock; all state updates on rising edge.
REQ-008 i_nrst  input  1  reset, asynchronous, active-low.
REQ-009 i_clear  input  1  synchronous flush.
REQ-010 i_write_en  input  1  write one entry this cycle.
REQ-011 i_data  input  DATA_WIDTH  write data.
REQ-012 i_pop_en  input  1  pop request this cycle.
REQ-013 i_pop_count  input  PCNT_WIDTH  requested entries per pop.
REQ-014 o_data  output  [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  popped entries; lane 0 is the oldest.
REQ-015 o_valid  output  DATA_LENGTH  per-lane valid for o_data.
REQ-016 o_count  output  CNT_WIDTH  current occupancy.
REQ-017 o_empty, o_full  output  1 each  status flags.

Function
REQ-018 The write SHALL be accepted when i_write_en=1 and o_full=0; a rejected write SHALL leave storage, pointers and count unchanged.
REQ-019 An accepted write SHALL store i_data at fifo[w_ptr]; w_ptr then SHALL advance by 1 modulo DEPTH.
REQ-020 The requested count SHALL be req = min(i_pop_count, DATA_LENGTH).
REQ-021 The pop grant SHALL be g = i_pop_en ? min(req, o_count) : 0, with o_count taken before the edge; a write in the same cycle SHALL NOT be poppable that cycle.
REQ-022 For each lane k < g, the block SHALL register o_data[k] <= fifo[(r_ptr+k) mod DEPTH] and o_valid[k] <= 1.
REQ-023 For each lane k >= g, the block SHALL register o_data[k] <= 0 and o_valid[k] <= 0.
REQ-024 After a pop, r_ptr SHALL advance by g modulo DEPTH.
REQ-025 Pop latency SHALL be one cycle; o_valid SHALL be a single-cycle pulse and SHALL be all-zero in any cycle following an edge with g=0.
REQ-026 On each edge, count SHALL become count + write_accepted - g.
REQ-027 A simultaneous write and pop SHALL both take effect on the same edge.
REQ-028 A write and pop on a full FIFO SHALL reject the write and perform the pop.
REQ-029 o_full SHALL equal (count == DEPTH).
REQ-030 o_empty SHALL equal (count == 0).
REQ-031 o_full and o_empty SHALL be combinational from count; o_count SHALL equal count.
REQ-032 i_clear SHALL take priority over write and pop; it SHALL zero w_ptr, r_ptr, count, o_data and o_valid, and SHALL leave storage contents undefined.
REQ-033 A pop window that crosses index DEPTH-1 SHALL wrap to index 0 without a gap.

Reset
REQ-034 While i_nrst=0, the block SHALL asynchronously force w_ptr=0, r_ptr=0, count=0, o_data=0 and o_valid=0.
REQ-035 With those values, o_empty SHALL be 1 and o_full 0 during reset; storage SHALL NOT be reset.
REQ-036 Reset asserted mid-pop SHALL discard the pending o_valid pulse; the first edge after release SHALL behave as from empty.

Configuration
REQ-037 With SIMO_FIFO_ERR_EN defined, the block SHALL add output o_err (1 bit, sticky) that sets when i_write_en=1 with o_full=1, or when i_pop_en=1 with req > o_count.
REQ-038 With SIMO_FIFO_ERR_EN defined, o_err SHALL be cleared only by reset or i_clear.
REQ-039 Without SIMO_FIFO_ERR_EN, port o_err SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, write 0x01..0x09 on consecutive cycles, then pop with i_pop_count=9 -> next cycle o_data lanes 0..8 = 0x01..0x09, o_valid=9'h1FF, o_count=0, o_empty=1.
REQ-041 Write 3 entries 0xA0..0xA2, then pop with i_pop_count=5 -> lanes 0..2 = 0xA0..0xA2, o_valid=9'h007, lanes 3..8=0, o_err=1 when SIMO_FIFO_ERR_EN is defined.
REQ-042 Fill to 32 -> o_full=1; write 0xFF -> rejected, o_count stays 32; write and pop 4 together -> o_count=28, write dropped.
REQ-043 Advance r_ptr to 30 with 6 entries held, then pop 6 -> entries from indices 30,31,0,1,2,3 appear in order on lanes 0..5.
REQ-044 Count=5 with write 0x55 and pop 2 in the same cycle -> o_count=4 next cycle; 0x55 is popped last.
REQ-045 Count=10, then assert i_clear together with i_write_en and i_pop_en -> o_count=0, o_valid=0, o_empty=1; assert i_nrst low mid-pop -> o_valid=0 immediately.
